// File: rtl/adau_spi_pkg.sv
// adau_spi_pkg
// Shared definitions for the parametrised ADAU SPI master:
//   - spi_state_e : transfer FSM states
//   - SPI_MODE0   : {CPOL, CPHA} of the serial link (mode 0, clock idles low)
//   - nb_width()  : width of the byte-count input for a given word width
//   - cs_width()  : width of the latch-select input for a given latch count
package adau_spi_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2,
    S_GAP   = 2'd3
  } spi_state_e;

  localparam logic [1:0] SPI_MODE0 = 2'b00;

  function automatic int nb_width(input int data_w);
    return $clog2(data_w / 8 + 1);
  endfunction

  function automatic int cs_width(input int num_cs);
    return (num_cs <= 1) ? 1 : $clog2(num_cs);
  endfunction

endpackage

// File: rtl/adau_spi_bitclk.sv
// adau_spi_bitclk
// Divided serial clock generator. While enabled, cclk spends CLK_DIV clk
// cycles low and then CLK_DIV cycles high, starting low. The strobes are
// high in the clk cycle whose closing edge makes cclk rise or fall, so the
// parent can sample or shift on that same edge.
// Ports:
//   clk        in  system clock
//   reset_n    in  synchronous active-low reset
//   en_i       in  run the divider; when low the phase restarts, cclk low
//   cclk_o     out serial clock (idle level from SPI_MODE0)
//   rise_stb_o out cclk rises at the next clk edge
//   fall_stb_o out cclk falls at the next clk edge
module adau_spi_bitclk
  import adau_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  output logic cclk_o,
  output logic rise_stb_o,
  output logic fall_stb_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          cclk_q;
  logic          last_phase;

  assign last_phase = (cnt_q == CW'(CLK_DIV - 1));
  assign rise_stb_o = en_i && last_phase && !cclk_q;
  assign fall_stb_o = en_i && last_phase && cclk_q;
  // Internal phase is always low-first; CPOL only inverts the pin.
  assign cclk_o     = cclk_q ^ SPI_MODE0[1];

  always_ff @(posedge clk) begin
    if (!reset_n || !en_i) begin
      cnt_q  <= '0;
      cclk_q <= 1'b0;
    end else if (last_phase) begin
      cnt_q  <= '0;
      cclk_q <= ~cclk_q;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/adau_spi_master_param.sv
// adau_spi_master_param
// Serialises a variable-length MSB-first command word onto cdata/cclk
// (SPI mode 0) under one active-low latch line, capturing cout on every
// cclk rising edge. The captured bits are presented right-aligned on rdata
// with a one-cycle rvalid pulse when the master returns to idle.
// Ports:
//   clk, reset_n  clock, synchronous active-low reset
//   data_in       command word, MSB-aligned
//   nbytes        bytes to send (0 or > DATA_W/8 means DATA_W/8)
//   cs_sel        latch index; out-of-range selects no latch
//   valid/ready   command handshake, accepted on valid && ready
//   rdata/rvalid  read-back word and its update pulse
//   cout          serial input from the peripheral
//   cdata, cclk   serial output and clock
//   clatch_n      active-low latch outputs
module adau_spi_master_param
  import adau_spi_pkg::*;
#(
  parameter  int DATA_W    = 32,
  parameter  int CLK_DIV   = 4,
  parameter  int NUM_CS    = 1,
  parameter  int LATCH_GAP = 2,
  localparam int NB_W      = nb_width(DATA_W),
  localparam int CS_W      = cs_width(NUM_CS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic [NB_W-1:0]   nbytes,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              valid,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  input  logic              cout,
  output logic              cdata,
  output logic              cclk,
  output logic [NUM_CS-1:0] clatch_n
);

  localparam int MAX_BYTES = DATA_W / 8;
  localparam int BC_W      = $clog2(DATA_W + 1);
  localparam int WMAX      = (CLK_DIV > LATCH_GAP) ? CLK_DIV : LATCH_GAP;
  localparam int WC_W      = $clog2(WMAX + 1);

  spi_state_e        state_q;
  logic              ready_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              cdata_q;
  logic [NUM_CS-1:0] clatch_q;
  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] rx_q;
  logic [BC_W-1:0]   nbits_q;
  logic [BC_W-1:0]   bit_cnt_q;
  logic [WC_W-1:0]   wcnt_q;
  logic              rise_stb;
  logic              fall_stb;

  // Bit count after the zero / oversize substitution.
  function automatic logic [BC_W-1:0] nbits_of(input logic [NB_W-1:0] nb);
    int n;
    n = int'(nb);
    if (n == 0 || n > MAX_BYTES) n = MAX_BYTES;
    return BC_W'(n * 8);
  endfunction

  // One-cold latch pattern; an index past the last latch asserts nothing.
  function automatic logic [NUM_CS-1:0] latch_mask(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] m;
    m = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(sel) == i) m[i] = 1'b0;
    end
    return m;
  endfunction

  adau_spi_bitclk #(
    .CLK_DIV(CLK_DIV)
  ) u_bitclk (
    .clk       (clk),
    .reset_n   (reset_n),
    .en_i      (state_q == S_SHIFT),
    .cclk_o    (cclk),
    .rise_stb_o(rise_stb),
    .fall_stb_o(fall_stb)
  );

  assign ready    = ready_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign cdata    = cdata_q;
  assign clatch_n = clatch_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      cdata_q   <= 1'b0;
      clatch_q  <= '1;
      bit_cnt_q <= '0;
      wcnt_q    <= '0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (valid) begin
            state_q   <= S_SHIFT;
            ready_q   <= 1'b0;
            tx_q      <= data_in;
            rx_q      <= '0;
            cdata_q   <= data_in[DATA_W-1];
            nbits_q   <= nbits_of(nbytes);
            clatch_q  <= latch_mask(cs_sel);
            bit_cnt_q <= '0;
            wcnt_q    <= '0;
          end
        end
        S_SHIFT: begin
          if (rise_stb) rx_q <= {rx_q[DATA_W-2:0], cout};
          if (fall_stb) begin
            // The falling edge closing the last high phase ends shifting.
            if (bit_cnt_q == nbits_q - 1'b1) begin
              state_q <= S_HOLD;
              cdata_q <= 1'b0;
              wcnt_q  <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              tx_q      <= {tx_q[DATA_W-2:0], 1'b0};
              cdata_q   <= tx_q[DATA_W-2];
            end
          end
        end
        S_HOLD: begin
          if (wcnt_q == WC_W'(CLK_DIV - 1)) begin
            state_q  <= S_GAP;
            clatch_q <= '1;
            wcnt_q   <= '0;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (wcnt_q == WC_W'(LATCH_GAP - 1)) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b1;
            rdata_q  <= rx_q;
            rvalid_q <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adau_spi_master_param.sv
module tb_adau_spi_master_param;

  localparam int DW  = 32;
  localparam int CD  = 2;
  localparam int NCS = 3;
  localparam int LG  = 2;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [DW-1:0]  data_in;
  logic [2:0]     nbytes;
  logic [1:0]     cs_sel;
  logic           valid;
  logic           ready;
  logic [DW-1:0]  rdata;
  logic           rvalid;
  logic           cout;
  logic           cdata;
  logic           cclk;
  logic [NCS-1:0] clatch_n;

  // Peripheral model: echo cdata, or play a bit pattern indexed by pulse.
  logic           loop_en;
  logic [63:0]    pat;
  logic [5:0]     pidx;
  assign cout = loop_en ? cdata : pat[pidx];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adau_spi_master_param #(
    .DATA_W(DW), .CLK_DIV(CD), .NUM_CS(NCS), .LATCH_GAP(LG)
  ) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .nbytes(nbytes),
    .cs_sel(cs_sel), .valid(valid), .ready(ready), .rdata(rdata),
    .rvalid(rvalid), .cout(cout), .cdata(cdata), .cclk(cclk),
    .clatch_n(clatch_n)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference rules
  function automatic int model_nbits(input int nb);
    return (nb == 0 || nb > DW / 8) ? DW : nb * 8;
  endfunction

  function automatic logic [NCS-1:0] model_mask(input int cs);
    return (cs < NCS) ? ~(NCS'(1) << cs) : {NCS{1'b1}};
  endfunction

  function automatic logic [31:0] model_rx(input logic [63:0] p, input int nbits);
    logic [31:0] r;
    r = 0;
    for (int i = 0; i < nbits; i++) r = {r[30:0], p[i]};
    return r;
  endfunction

  task automatic run_xfer(input string tag, input logic [31:0] d, input int nb, input int cs,
                          input bit lp, input logic [63:0] p, input int exp_nbits,
                          input logic [31:0] exp_rd);
    int k, pulses, low_sel, low_bad, rdy_at, early_rv;
    logic prev_cclk;
    logic [63:0] dec, exp_sent;
    logic [NCS-1:0] m;
    bit done;
    m = model_mask(cs);
    exp_sent = {32'b0, d} >> (32 - exp_nbits);
    @(negedge clk);
    check({tag, "_idle_ready"}, ready, 1);
    data_in = d; nbytes = nb[2:0]; cs_sel = cs[1:0]; valid = 1'b1;
    loop_en = lp; pat = p; pidx = 0;
    @(posedge clk); #1;
    valid = 1'b0; data_in = $urandom; nbytes = 3'($urandom); cs_sel = 2'($urandom);
    check({tag, "_first_cclk"}, cclk, 0);
    check({tag, "_first_cdata"}, cdata, d[31]);
    check({tag, "_first_latch"}, clatch_n, m);
    k = 1; pulses = 0; low_sel = 0; low_bad = 0; rdy_at = -1; early_rv = 0;
    prev_cclk = 1'b0; dec = 0; done = 0;
    while (!done && k < 2000) begin
      if (cclk && !prev_cclk) begin
        dec = {dec[62:0], cdata};
        pulses++;
        pidx = 6'(pulses);
      end
      prev_cclk = cclk;
      if (clatch_n != {NCS{1'b1}}) begin
        if (clatch_n == m) low_sel++;
        else low_bad++;
      end
      if (ready) begin
        rdy_at = k;
        done = 1;
        check({tag, "_rvalid_at_ready"}, rvalid, 1);
        check({tag, "_rdata"}, rdata, exp_rd);
      end else begin
        if (rvalid) early_rv++;
        @(posedge clk); #1;
        k++;
      end
    end
    check({tag, "_not_timeout"}, done, 1);
    check({tag, "_pulses"}, pulses, exp_nbits);
    check({tag, "_sent_bits"}, dec, exp_sent);
    check({tag, "_latch_low"}, low_sel, (cs < NCS) ? 2 * CD * exp_nbits + CD : 0);
    check({tag, "_wrong_latch"}, low_bad, 0);
    check({tag, "_ready_latency"}, rdy_at, 1 + 2 * CD * exp_nbits + CD + LG);
    check({tag, "_early_rvalid"}, early_rv, 0);
    @(posedge clk); #1;
    check({tag, "_rvalid_one_cycle"}, rvalid, 0);
  endtask

  typedef struct {
    logic [31:0] data;
    int          nb;
    int          cs;
    int          exp_nbits;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int gap, phase, acc, rvc, pulses, k;
    bit acc_next;
    logic [31:0] rd[2];
    logic [31:0] rdat, w1, w2;
    int rnb, rcs, rnbits;
    logic [63:0] rpat;

    vecs[0] = '{32'hA5C3_0F01, 4, 0, 32, 32'hA5C3_0F01};
    vecs[1] = '{32'h8000_0000, 1, 0,  8, 32'h0000_0080};
    vecs[2] = '{32'h1234_5678, 2, 2, 16, 32'h0000_1234};
    vecs[3] = '{32'hDEAD_BEEF, 0, 1, 32, 32'hDEAD_BEEF};
    vecs[4] = '{32'hCAFE_BABE, 7, 3, 32, 32'hCAFE_BABE};
    vecs[5] = '{32'h5A3C_9900, 3, 1, 24, 32'h005A_3C99};

    reset_n = 1'b0; valid = 1'b1; data_in = 32'hFFFF_FFFF; nbytes = 3'd4; cs_sel = 2'd0;
    loop_en = 1'b1; pat = 0; pidx = 0;

    // Reset held with valid asserted: nothing may start.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_ready", ready, 1);
      check("rst_latch", clatch_n, {NCS{1'b1}});
      check("rst_cclk", cclk, 0);
      check("rst_cdata", cdata, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rdata", rdata, 0);
    end
    @(negedge clk);
    reset_n = 1'b1; valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", {ready, clatch_n}, {1'b1, {NCS{1'b1}}});

    foreach (vecs[i])
      run_xfer($sformatf("vec%0d", i), vecs[i].data, vecs[i].nb, vecs[i].cs, 1'b1, 64'd0,
               vecs[i].exp_nbits, vecs[i].exp_rd);

    for (int i = 0; i < 8; i++) begin
      rdat = $urandom; rnb = $urandom_range(0, 6); rcs = $urandom_range(0, 3);
      rpat = {$urandom, $urandom};
      rnbits = model_nbits(rnb);
      run_xfer($sformatf("rnd%0d", i), rdat, rnb, rcs, 1'b0, rpat, rnbits, model_rx(rpat, rnbits));
    end

    // Back-to-back: valid stays high across two words.
    w1 = 32'h0F1E_2D3C; w2 = 32'hC3B2_A190;
    @(negedge clk);
    data_in = w1; nbytes = 3'd4; cs_sel = 2'd1; valid = 1'b1; loop_en = 1'b1;
    acc = 0; acc_next = ready; phase = 0; gap = 0; rvc = 0; k = 0;
    while (rvc < 2 && k < 800) begin
      @(posedge clk); #1;
      k++;
      if (acc_next) begin
        acc++;
        if (acc == 1) data_in = w2;
        else valid = 1'b0;
      end
      acc_next = ready && valid;
      if (rvalid) begin
        rd[rvc] = rdata;
        rvc++;
      end
      case (phase)
        0: if (!clatch_n[1]) phase = 1;
        1: if (clatch_n[1]) begin phase = 2; gap = 1; end
        2: if (clatch_n[1]) gap++; else phase = 3;
        default: ;
      endcase
    end
    valid = 1'b0;
    check("b2b_rvalid_count", rvc, 2);
    check("b2b_accepts", acc, 2);
    // Latch stays high for the LATCH_GAP cycles plus the single idle cycle
    // in which the next word is accepted.
    check("b2b_gap", gap, LG + 1);
    check("b2b_rdata0", rd[0], w1);
    check("b2b_rdata1", rd[1], w2);

    // Abort during bit 10.
    @(negedge clk);
    data_in = 32'hFFFF_FFFF; nbytes = 3'd4; cs_sel = 2'd0; valid = 1'b1; loop_en = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    pulses = 0; k = 0;
    while (pulses < 10 && k < 500) begin
      @(posedge clk); #1;
      k++;
      if (cclk && k > 0 && (k % (2 * CD)) == CD) pulses++;
    end
    check("abort_reached_bit10", pulses, 10);
    check("abort_busy", ready, 0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("abort_ready", ready, 1);
    check("abort_latch", clatch_n, {NCS{1'b1}});
    check("abort_cclk", cclk, 0);
    check("abort_cdata", cdata, 0);
    check("abort_rdata", rdata, 0);
    reset_n = 1'b1;
    rvc = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (rvalid || !ready) rvc++;
    end
    check("abort_no_rvalid", rvc, 0);
    run_xfer("after_abort", 32'h3C00_0000, 1, 2, 1'b1, 64'd0, 8, 32'h0000_003C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
